data_mem_stage: RTL and testbench

DATA_MEM_STAGE -- requirements
Module: data_mem_stage

---
 rtl/data_mem_stage_if.sv | 26 ++
 rtl/data_mem_stage.sv | 161 ++++++++++++++++
 tb/tb_data_mem_stage.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/data_mem_stage_if.sv
// Bus between the EX/MEM register, the data-memory stage and the MEM/WB register.
// master drives the pipeline-side controls and address/data; slave is the memory stage.
interface data_mem_stage_if;
    logic [1:0]  WB_IN;
    logic [1:0]  M_IN;
    logic [2:0]  sizeIn;
    logic [31:0] ALUResultIn;
    logic [31:0] writeDataIn;
    logic [4:0]  WB_addressIn;
    logic [1:0]  WB;
    logic [31:0] ALUResult;
    logic [31:0] memRead;
    logic [4:0]  WB_address;
    logic        stall;
    logic        misaligned;

    modport master (
        output WB_IN, M_IN, sizeIn, ALUResultIn, writeDataIn, WB_addressIn,
        input  WB, ALUResult, memRead, WB_address, stall, misaligned
    );

    modport slave (
        input  WB_IN, M_IN, sizeIn, ALUResultIn, writeDataIn, WB_addressIn,
        output WB, ALUResult, memRead, WB_address, stall, misaligned
    );
endinterface

// File: rtl/data_mem_stage.sv
// Pipeline data-memory stage: single-cycle byte-enabled stores and two-cycle loads
// (one stall cycle), with alignment checking and size/sign extension of load data.
module data_mem_stage #(
    parameter int DEPTH_WORDS = 256
) (
    input logic            clk,
    input logic            rst,
    data_mem_stage_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic {
        IDLE,
        LOAD_WAIT
    } state_t;

    state_t state;
    state_t next_state;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   rd_word;
    logic [1:0]    rd_lane;
    logic [2:0]    rd_size;

    logic [AW-1:0] word_idx;
    logic [1:0]    lane;
    logic          is_byte;
    logic          is_half;
    logic          is_word;
    logic          want_write;
    logic          want_read;
    logic          access;
    logic          mis;
    logic [3:0]    byte_en;
    logic [31:0]   wr_data;
    logic          do_load;
    logic          do_store;
    logic [31:0]   load_ext;
    logic [7:0]    sel_byte;
    logic [15:0]   sel_half;

    assign word_idx   = bus.ALUResultIn[AW+1:2];
    assign lane       = bus.ALUResultIn[1:0];
    assign want_write = bus.M_IN[0];
    assign want_read  = bus.M_IN[1] & ~bus.M_IN[0];
    assign access     = bus.M_IN[1] | bus.M_IN[0];

    assign bus.ALUResult  = bus.ALUResultIn;
    assign bus.WB_address = bus.WB_addressIn;

    // Unlisted size codes fall into the word class.
    always_comb begin
        is_byte = 1'b0;
        is_half = 1'b0;
        case (bus.sizeIn)
            3'b000, 3'b100: is_byte = 1'b1;
            3'b001, 3'b101: is_half = 1'b1;
            default:        is_byte = 1'b0;
        endcase
        is_word = ~is_byte & ~is_half;
        mis     = (is_half & lane[0]) | (is_word & (lane != 2'b00));
    end

    always_comb begin
        byte_en = 4'b1111;
        wr_data = bus.writeDataIn;
        if (is_byte) begin
            byte_en = 4'b0001 << lane;
            wr_data = {4{bus.writeDataIn[7:0]}};
        end else if (is_half) begin
            byte_en = lane[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{bus.writeDataIn[15:0]}};
        end
    end

    // Lane selection and extension work on the address captured with the load.
    always_comb begin
        sel_byte = rd_word[7:0];
        case (rd_lane)
            2'b01:   sel_byte = rd_word[15:8];
            2'b10:   sel_byte = rd_word[23:16];
            2'b11:   sel_byte = rd_word[31:24];
            default: sel_byte = rd_word[7:0];
        endcase
        sel_half = rd_lane[1] ? rd_word[31:16] : rd_word[15:0];
        case (rd_size)
            3'b000:  load_ext = {{24{sel_byte[7]}}, sel_byte};
            3'b100:  load_ext = {24'b0, sel_byte};
            3'b001:  load_ext = {{16{sel_half[15]}}, sel_half};
            3'b101:  load_ext = {16'b0, sel_half};
            default: load_ext = rd_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Stores take priority when both memRead and memWrite are requested.
    always_comb begin
        next_state      = state;
        bus.stall       = 1'b0;
        bus.misaligned  = 1'b0;
        bus.WB          = bus.WB_IN;
        bus.memRead     = 32'b0;
        do_load         = 1'b0;
        do_store        = 1'b0;
        if (rst) begin
            next_state = IDLE;
            bus.WB     = 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (access && mis) begin
                        bus.misaligned = 1'b1;
                        bus.WB         = 2'b00;
                    end else if (want_write) begin
                        do_store = 1'b1;
                    end else if (want_read) begin
                        do_load    = 1'b1;
                        bus.stall  = 1'b1;
                        bus.WB     = 2'b00;
                        next_state = LOAD_WAIT;
                    end
                end
                LOAD_WAIT: begin
                    bus.memRead = load_ext;
                    next_state  = IDLE;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_word <= 32'b0;
            rd_lane <= 2'b00;
            rd_size <= 3'b000;
        end else if (do_load) begin
            rd_word <= mem[word_idx];
            rd_lane <= lane;
            rd_size <= bus.sizeIn;
        end
    end

    // The array itself is never reset so data survives a pipeline flush.
    always_ff @(posedge clk) begin
        if (do_store) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_data_mem_stage.sv
// Directed bench for data_mem_stage: stimulus pushes expected load results into a
// scoreboard, a negedge monitor pops them when a load completes.
module tb_data_mem_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic started = 1'b0;
    logic prev_stall = 1'b0;
    int   total = 0;
    int   bad = 0;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic [1:0]  wb;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    data_mem_stage_if bus();

    data_mem_stage #(.DEPTH_WORDS(256)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a completed load is the first non-stall cycle after a stall.
    always @(negedge clk) begin
        if (started) begin
            if (!rst && prev_stall && !bus.stall) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_load: got %h expected none", bus.memRead);
                end else begin
                    e = sb.pop_front();
                    check_output({e.name, "_data"}, bus.memRead, e.data);
                    check_output({e.name, "_wb"}, {30'b0, bus.WB}, {30'b0, e.wb});
                end
            end else begin
                check_output("memread_zero", bus.memRead, 32'b0);
                if (prev_stall && bus.stall) begin
                    check_output("stall_len", {31'b0, bus.stall}, 32'b0);
                end
            end
        end
        prev_stall = bus.stall & started;
    end

    task automatic apply_stimulus(input string name, input logic [1:0] m, input logic [2:0] size,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [1:0] wb, input logic exp_stall, input logic exp_mis,
                                  input logic [1:0] exp_wb, input logic push,
                                  input logic [31:0] exp_data);
        logic [4:0] wb_addr;
        wb_addr = addr[6:2] ^ 5'h15;
        @(posedge clk);
        #1;
        bus.M_IN         = m;
        bus.sizeIn       = size;
        bus.ALUResultIn  = addr;
        bus.writeDataIn  = wdata;
        bus.WB_IN        = wb;
        bus.WB_addressIn = wb_addr;
        @(negedge clk);
        check_output({name, "_stall"}, {31'b0, bus.stall}, {31'b0, exp_stall});
        check_output({name, "_mis"}, {31'b0, bus.misaligned}, {31'b0, exp_mis});
        check_output({name, "_wbout"}, {30'b0, bus.WB}, {30'b0, exp_wb});
        check_output({name, "_alu"}, bus.ALUResult, addr);
        check_output({name, "_wbaddr"}, {27'b0, bus.WB_address}, {27'b0, wb_addr});
        if (push) begin
            sb.push_back('{name, exp_data, wb});
            @(posedge clk);
            #1;
            @(negedge clk);
        end
    endtask

    task automatic store(input string name, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] data);
        apply_stimulus(name, 2'b01, size, addr, data, 2'b10, 1'b0, 1'b0, 2'b10, 1'b0, 32'b0);
    endtask

    task automatic load(input string name, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] exp);
        apply_stimulus(name, 2'b10, size, addr, 32'hFFFF_FFFF, 2'b01, 1'b1, 1'b0, 2'b00, 1'b1, exp);
    endtask

    task automatic bad_access(input string name, input logic [1:0] m, input logic [2:0] size,
                              input logic [31:0] addr);
        apply_stimulus(name, m, size, addr, 32'hBAD0_BAD0, 2'b11, 1'b0, 1'b1, 2'b00, 1'b0, 32'b0);
    endtask

    initial begin
        bus.M_IN         = 2'b10;
        bus.sizeIn       = 3'b010;
        bus.ALUResultIn  = 32'h10;
        bus.writeDataIn  = 32'b0;
        bus.WB_IN        = 2'b11;
        bus.WB_addressIn = 5'd3;
        rst = 1'b1;
        @(posedge clk);
        started = 1'b1;
        @(negedge clk);
        check_output("rst_stall", {31'b0, bus.stall}, 32'b0);
        check_output("rst_mis", {31'b0, bus.misaligned}, 32'b0);
        check_output("rst_wb", {30'b0, bus.WB}, 32'b0);
        check_output("rst_memread", bus.memRead, 32'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.M_IN = 2'b00;

        apply_stimulus("pass", 2'b00, 3'b010, 32'h1234_5678, 32'b0, 2'b11,
                       1'b0, 1'b0, 2'b11, 1'b0, 32'b0);

        store("sw_10", 3'b010, 32'h10, 32'hDEAD_BEEF);
        load("lw_10", 3'b010, 32'h10, 32'hDEAD_BEEF);

        store("sw_20", 3'b010, 32'h20, 32'h0000_0000);
        store("sb_21", 3'b000, 32'h21, 32'hABCD_EF80);
        load("lb_21", 3'b000, 32'h21, 32'hFFFF_FF80);
        load("lbu_21", 3'b100, 32'h21, 32'h0000_0080);
        load("lw_20", 3'b010, 32'h20, 32'h0000_8000);

        bad_access("lh_13", 2'b10, 3'b001, 32'h13);
        bad_access("lw_12", 2'b10, 3'b010, 32'h12);
        bad_access("sw_11", 2'b01, 3'b010, 32'h11);
        bad_access("sh_15", 2'b01, 3'b101, 32'h15);
        load("lw_10_again", 3'b010, 32'h10, 32'hDEAD_BEEF);

        store("sw_30", 3'b010, 32'h30, 32'h1122_3344);
        store("sh_32", 3'b001, 32'h32, 32'h5555_9ABC);
        load("lh_32", 3'b001, 32'h32, 32'hFFFF_9ABC);
        load("lhu_32", 3'b101, 32'h32, 32'h0000_9ABC);
        load("lh_30", 3'b001, 32'h30, 32'h0000_3344);
        load("lb_30", 3'b000, 32'h30, 32'h0000_0044);
        load("lb_33", 3'b000, 32'h33, 32'hFFFF_FF9A);

        apply_stimulus("rw_40", 2'b11, 3'b010, 32'h40, 32'h55AA_55AA, 2'b10,
                       1'b0, 1'b0, 2'b10, 1'b0, 32'b0);
        load("lw_40", 3'b010, 32'h40, 32'h55AA_55AA);
        load("lsz3_40", 3'b011, 32'h40, 32'h55AA_55AA);

        store("sw_400", 3'b010, 32'h400, 32'h1111_1111);
        load("lw_000", 3'b010, 32'h000, 32'h1111_1111);

        apply_stimulus("lw_abort", 2'b10, 3'b010, 32'h10, 32'b0, 2'b11,
                       1'b1, 1'b0, 2'b00, 1'b0, 32'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_output("abort_stall", {31'b0, bus.stall}, 32'b0);
        check_output("abort_memread", bus.memRead, 32'b0);
        check_output("abort_wb", {30'b0, bus.WB}, 32'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.M_IN = 2'b00;
        @(negedge clk);
        check_output("after_abort_stall", {31'b0, bus.stall}, 32'b0);
        check_output("after_abort_wb", {30'b0, bus.WB}, 32'h3);
        load("lw_after_rst", 3'b010, 32'h10, 32'hDEAD_BEEF);

        apply_stimulus("idle_end", 2'b00, 3'b010, 32'h0, 32'b0, 2'b00,
                       1'b0, 1'b0, 2'b00, 1'b0, 32'b0);
        @(posedge clk);
        @(negedge clk);
        check_output("sb_drain", sb.size(), 32'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
